// File: rtl/tf_pkg.sv
// Shared state codes, light codes and display helpers for the actuated
// two-road intersection scheduler.
package tf_pkg;

    typedef enum logic [2:0] {
        S_G0 = 3'd0,
        S_Y0 = 3'd1,
        S_R0 = 3'd2,
        S_G1 = 3'd3,
        S_Y1 = 3'd4,
        S_R1 = 3'd5
    } state_t;

    localparam logic [2:0] TF_RED = 3'b100;
    localparam logic [2:0] TF_YEL = 3'b010;
    localparam logic [2:0] TF_GRN = 3'b001;

    localparam int TIMER_W  = 7;
    localparam int DISP_MAX = 99;

    // Countdown displays clip at two decimal digits.
    function automatic logic [TIMER_W-1:0] disp_sat(input int v);
        return (v > DISP_MAX) ? TIMER_W'(DISP_MAX) : TIMER_W'(v);
    endfunction

endpackage

// File: rtl/tf_tick_gen.sv
// Prescaler producing a registered one-cycle TICK every TICK_DIV clocks;
// TICK is high in the cycle the count sits at TICK_DIV-1.
module tf_tick_gen #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic CLK,
    input  logic RST,
    output logic TICK
);
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] PRE  = CW'(TICK_DIV - 2);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        tick_d = (cnt_q == PRE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign TICK = tick_q;

endmodule

// File: rtl/tf_actuated_sched.sv
// Actuated two-road phase scheduler: min/max green, gap extension, yellow
// and all-red clearance. Optional preemption under TF_EMERG_PREEMPT_EN.
module tf_actuated_sched
    import tf_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned T_GMIN   = 10,
    parameter int unsigned T_GMAX   = 40,
    parameter int unsigned T_EXT    = 5,
    parameter int unsigned T_YEL    = 3,
    parameter int unsigned T_CLR    = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                REQ0,
    input  logic                REQ1,
`ifdef TF_EMERG_PREEMPT_EN
    input  logic                EMG,
    input  logic                EMG_ROAD,
`endif
    output logic [TIMER_W-1:0]  TIMER0,
    output logic [2:0]          TF0,
    output logic [TIMER_W-1:0]  TIMER1,
    output logic [2:0]          TF1,
    output logic [2:0]          PHASE,
    output logic                TICK
);
    localparam logic [TIMER_W-1:0] GMIN_T = TIMER_W'(T_GMIN);
    localparam logic [TIMER_W-1:0] GMAX_T = TIMER_W'(T_GMAX);
    localparam logic [TIMER_W-1:0] EXT_T  = TIMER_W'(T_EXT);
    localparam logic [TIMER_W-1:0] YEL_T  = TIMER_W'(T_YEL);
    localparam logic [TIMER_W-1:0] CLR_T  = TIMER_W'(T_CLR);
    localparam logic [TIMER_W-1:0] GEL_MX = {TIMER_W{1'b1}};

    logic tick;

    tf_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .CLK  (CLK),
        .RST  (RST),
        .TICK (tick)
    );

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   tmr_q, tmr_d;
    logic [TIMER_W-1:0]   gel_q, gel_d;
    logic                 pend0_q, pend0_d, pend1_q, pend1_d;
    logic [TIMER_W-1:0]   timer0_q, timer0_d, timer1_q, timer1_d;
    logic [2:0]           tf0_q, tf0_d, tf1_q, tf1_d;
    logic                 own_req, other_pend, emg_hold, emg_yield;

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        gel_d      = gel_q;
        own_req    = (state_q == S_G1) ? REQ1 : REQ0;
        other_pend = (state_q == S_G1) ? pend0_q : pend1_q;
`ifdef TF_EMERG_PREEMPT_EN
        emg_hold   = EMG && (EMG_ROAD == (state_q == S_G1));
        emg_yield  = EMG && (EMG_ROAD != (state_q == S_G1));
`else
        emg_hold   = 1'b0;
        emg_yield  = 1'b0;
`endif
        if (tick) begin
            unique case (state_q)
                S_G0, S_G1: begin
                    gel_d = (gel_q == GEL_MX) ? gel_q : gel_q + 1'b1;
                    if (emg_yield || (!emg_hold && !(own_req && tmr_q <= EXT_T && gel_q < GMAX_T)
                                      && tmr_q <= 7'd1 && other_pend)) begin
                        state_d = (state_q == S_G0) ? S_Y0 : S_Y1;
                        tmr_d   = YEL_T;
                    end else if (emg_hold) begin
                        tmr_d = tmr_q;
                    end else if (own_req && tmr_q <= EXT_T && gel_q < GMAX_T) begin
                        tmr_d = EXT_T;
                    end else if (tmr_q > 7'd1) begin
                        tmr_d = tmr_q - 1'b1;
                    end else begin
                        // No competing demand: rest in green with the timer parked at 0.
                        tmr_d = '0;
                    end
                end
                S_Y0, S_Y1: begin
                    if (tmr_q <= 7'd1) begin
                        state_d = (state_q == S_Y0) ? S_R0 : S_R1;
                        tmr_d   = CLR_T;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                S_R0, S_R1: begin
                    if (tmr_q <= 7'd1) begin
                        state_d = (state_q == S_R0) ? S_G1 : S_G0;
                        tmr_d   = GMIN_T;
                        gel_d   = '0;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                default: begin
                    state_d = S_G0;
                    tmr_d   = GMIN_T;
                    gel_d   = '0;
                end
            endcase
        end

        // Entry into a road's green wins over a same-cycle request from that road.
        if (state_q != S_G0 && state_d == S_G0) pend0_d = 1'b0;
        else if (state_q != S_G0 && REQ0)       pend0_d = 1'b1;
        else                                    pend0_d = pend0_q;
        if (state_q != S_G1 && state_d == S_G1) pend1_d = 1'b0;
        else if (state_q != S_G1 && REQ1)       pend1_d = 1'b1;
        else                                    pend1_d = pend1_q;

        tf0_d    = TF_RED;
        tf1_d    = TF_RED;
        timer0_d = tmr_d;
        timer1_d = tmr_d;
        unique case (state_d)
            S_G0: begin tf0_d = TF_GRN; timer1_d = disp_sat(int'(tmr_d) + int'(T_YEL) + int'(T_CLR)); end
            S_Y0: begin tf0_d = TF_YEL; timer1_d = disp_sat(int'(tmr_d) + int'(T_CLR)); end
            S_G1: begin tf1_d = TF_GRN; timer0_d = disp_sat(int'(tmr_d) + int'(T_YEL) + int'(T_CLR)); end
            S_Y1: begin tf1_d = TF_YEL; timer0_d = disp_sat(int'(tmr_d) + int'(T_CLR)); end
            default: ;
        endcase
        timer0_d = disp_sat(int'(timer0_d));
        timer1_d = disp_sat(int'(timer1_d));
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_G0;
            tmr_q    <= GMIN_T;
            gel_q    <= '0;
            pend0_q  <= 1'b0;
            pend1_q  <= 1'b0;
            tf0_q    <= TF_GRN;
            tf1_q    <= TF_RED;
            timer0_q <= disp_sat(int'(T_GMIN));
            timer1_q <= disp_sat(int'(T_GMIN) + int'(T_YEL) + int'(T_CLR));
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            gel_q    <= gel_d;
            pend0_q  <= pend0_d;
            pend1_q  <= pend1_d;
            tf0_q    <= tf0_d;
            tf1_q    <= tf1_d;
            timer0_q <= timer0_d;
            timer1_q <= timer1_d;
        end
    end

    assign TIMER0 = timer0_q;
    assign TIMER1 = timer1_q;
    assign TF0    = tf0_q;
    assign TF1    = tf1_q;
    assign PHASE  = state_q;
    assign TICK   = tick;

endmodule

// File: tb/tb_tf_actuated_sched.sv
// Directed bench for tf_actuated_sched with TICK_DIV=4, T_GMIN=3, T_GMAX=8,
// T_EXT=2, T_YEL=2, T_CLR=1.
module tb_tf_actuated_sched;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       REQ0 = 1'b0;
    logic       REQ1 = 1'b0;
`ifdef TF_EMERG_PREEMPT_EN
    logic       EMG = 1'b0;
    logic       EMG_ROAD = 1'b0;
`endif
    logic [6:0] TIMER0, TIMER1;
    logic [2:0] TF0, TF1, PHASE;
    logic       TICK;
    int         checks = 0;
    int         errors = 0;

    always #5 CLK = ~CLK;

    tf_actuated_sched #(
        .TICK_DIV(4), .T_GMIN(3), .T_GMAX(8), .T_EXT(2), .T_YEL(2), .T_CLR(1)
    ) dut (
        .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1),
`ifdef TF_EMERG_PREEMPT_EN
        .EMG(EMG), .EMG_ROAD(EMG_ROAD),
`endif
        .TIMER0(TIMER0), .TF0(TF0), .TIMER1(TIMER1), .TF1(TF1),
        .PHASE(PHASE), .TICK(TICK)
    );

    // Advance to just past the next tick edge; the FSM update is then visible.
    task automatic next_tick();
        int n = 0;
        while (TICK !== 1'b1 && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        if (TICK !== 1'b1) begin
            checks++; errors++;
            $display("FAIL tick_timeout got TICK=%b want 1", TICK);
        end
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        @(negedge CLK) RST = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (TF0 !== 3'b001) begin errors++; $display("FAIL rst_tf0 got %b want 001", TF0); end
        checks++; if (TF1 !== 3'b100) begin errors++; $display("FAIL rst_tf1 got %b want 100", TF1); end
        checks++; if (TIMER0 !== 7'd3) begin errors++; $display("FAIL rst_timer0 got %0d want 3", TIMER0); end
        checks++; if (TIMER1 !== 7'd6) begin errors++; $display("FAIL rst_timer1 got %0d want 6", TIMER1); end
        checks++; if (PHASE !== 3'd0) begin errors++; $display("FAIL rst_phase got %0d want 0", PHASE); end
        checks++; if (TICK !== 1'b0) begin errors++; $display("FAIL rst_tick got %b want 0", TICK); end
        @(negedge CLK) RST = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge CLK); #1;
            checks++;
            if (TICK !== (i == 3)) begin
                errors++; $display("FAIL first_tick cycle %0d got %b want %b", i + 1, TICK, (i == 3));
            end
        end
    endtask

    task automatic test_rest_green();
        logic [6:0] e0;
        for (int k = 1; k <= 20; k++) begin
            next_tick();
            e0 = (k >= 3) ? 7'd0 : 7'(3 - k);
            checks++; if (PHASE !== 3'd0) begin errors++; $display("FAIL rest_phase tick %0d got %0d want 0", k, PHASE); end
            checks++; if (TIMER0 !== e0) begin errors++; $display("FAIL rest_timer0 tick %0d got %0d want %0d", k, TIMER0, e0); end
            checks++; if (TIMER1 !== e0 + 7'd3) begin errors++; $display("FAIL rest_timer1 tick %0d got %0d want %0d", k, TIMER1, e0 + 7'd3); end
        end
    endtask

    task automatic test_req1_pulse();
        do_reset();
        next_tick();
        REQ1 = 1'b1;
        @(posedge CLK); #1;
        REQ1 = 1'b0;
        next_tick();
        checks++; if (PHASE !== 3'd0) begin errors++; $display("FAIL pulse_t2_phase got %0d want 0", PHASE); end
        next_tick();
        checks++; if (PHASE !== 3'd1) begin errors++; $display("FAIL pulse_y0_phase got %0d want 1", PHASE); end
        checks++; if (TF0 !== 3'b010) begin errors++; $display("FAIL pulse_y0_tf0 got %b want 010", TF0); end
        checks++; if (TF1 !== 3'b100) begin errors++; $display("FAIL pulse_y0_tf1 got %b want 100", TF1); end
        checks++; if (TIMER0 !== 7'd2) begin errors++; $display("FAIL pulse_y0_timer0 got %0d want 2", TIMER0); end
        checks++; if (TIMER1 !== 7'd3) begin errors++; $display("FAIL pulse_y0_timer1 got %0d want 3", TIMER1); end
        next_tick();
        checks++; if (PHASE !== 3'd1) begin errors++; $display("FAIL pulse_y0b_phase got %0d want 1", PHASE); end
        next_tick();
        checks++; if (PHASE !== 3'd2) begin errors++; $display("FAIL pulse_r0_phase got %0d want 2", PHASE); end
        checks++; if (TF0 !== 3'b100 || TF1 !== 3'b100) begin errors++; $display("FAIL pulse_r0_tf got %b/%b want 100/100", TF0, TF1); end
        checks++; if (TIMER0 !== 7'd1) begin errors++; $display("FAIL pulse_r0_timer0 got %0d want 1", TIMER0); end
        next_tick();
        checks++; if (PHASE !== 3'd3) begin errors++; $display("FAIL pulse_g1_phase got %0d want 3", PHASE); end
        checks++; if (TF1 !== 3'b001 || TF0 !== 3'b100) begin errors++; $display("FAIL pulse_g1_tf got %b/%b want 100/001", TF0, TF1); end
        checks++; if (TIMER1 !== 7'd3) begin errors++; $display("FAIL pulse_g1_timer1 got %0d want 3", TIMER1); end
        checks++; if (TIMER0 !== 7'd6) begin errors++; $display("FAIL pulse_g1_timer0 got %0d want 6", TIMER0); end
    endtask

    task automatic test_extend();
        do_reset();
        REQ0 = 1'b1;
        REQ1 = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            next_tick();
            checks++; if (PHASE !== 3'd0) begin errors++; $display("FAIL ext_g0_phase tick %0d got %0d want 0", k, PHASE); end
        end
        checks++; if (TIMER0 !== 7'd1) begin errors++; $display("FAIL ext_t9_timer0 got %0d want 1", TIMER0); end
        next_tick();
        checks++; if (PHASE !== 3'd1) begin errors++; $display("FAIL ext_y0_phase got %0d want 1", PHASE); end
        repeat (3) next_tick();
        checks++; if (PHASE !== 3'd3) begin errors++; $display("FAIL ext_g1_phase got %0d want 3", PHASE); end
        repeat (9) next_tick();
        checks++; if (PHASE !== 3'd3) begin errors++; $display("FAIL ext_g1_hold got %0d want 3", PHASE); end
        next_tick();
        checks++; if (PHASE !== 3'd4) begin errors++; $display("FAIL ext_y1_phase got %0d want 4", PHASE); end
        REQ0 = 1'b0;
        REQ1 = 1'b0;
    endtask

    task automatic test_reset_mid_y();
        do_reset();
        next_tick();
        REQ1 = 1'b1;
        @(posedge CLK); #1;
        REQ1 = 1'b0;
        repeat (2) next_tick();
        checks++; if (PHASE !== 3'd1) begin errors++; $display("FAIL midy_setup got %0d want 1", PHASE); end
        RST = 1'b0;
        #1;
        checks++; if (PHASE !== 3'd0) begin errors++; $display("FAIL midy_phase got %0d want 0", PHASE); end
        checks++; if (TF0 !== 3'b001 || TF1 !== 3'b100) begin errors++; $display("FAIL midy_tf got %b/%b want 001/100", TF0, TF1); end
        checks++; if (TIMER0 !== 7'd3) begin errors++; $display("FAIL midy_timer0 got %0d want 3", TIMER0); end
        @(negedge CLK) RST = 1'b1;
        repeat (4) next_tick();
        checks++; if (PHASE !== 3'd0) begin errors++; $display("FAIL midy_pend_cleared got %0d want 0", PHASE); end
        checks++; if (TIMER0 !== 7'd0) begin errors++; $display("FAIL midy_rest_timer0 got %0d want 0", TIMER0); end
    endtask

`ifdef TF_EMERG_PREEMPT_EN
    task automatic test_emerg();
        do_reset();
        EMG = 1'b1;
        EMG_ROAD = 1'b1;
        next_tick();
        checks++; if (PHASE !== 3'd1) begin errors++; $display("FAIL emg_y0 got %0d want 1", PHASE); end
        repeat (2) next_tick();
        checks++; if (PHASE !== 3'd2) begin errors++; $display("FAIL emg_r0 got %0d want 2", PHASE); end
        next_tick();
        checks++; if (PHASE !== 3'd3) begin errors++; $display("FAIL emg_g1 got %0d want 3", PHASE); end
        repeat (4) next_tick();
        checks++; if (PHASE !== 3'd3 || TIMER1 !== 7'd3) begin errors++; $display("FAIL emg_hold got %0d/%0d want 3/3", PHASE, TIMER1); end
        EMG = 1'b0;
        next_tick();
        checks++; if (TIMER1 !== 7'd2) begin errors++; $display("FAIL emg_release got %0d want 2", TIMER1); end
    endtask
`endif

    initial begin
        test_reset();
        test_rest_green();
        test_req1_pulse();
        test_extend();
        test_reset_mid_y();
`ifdef TF_EMERG_PREEMPT_EN
        test_emerg();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
